// File: rtl/huffman_encoder.sv
// Serial canonical-Huffman encoder for symbols 1..18, one code bit per clock, MSB first.
// Optional saturating statistics counters are enabled by defining HUFF_ENC_STATS_EN.
module huffman_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             enc_err
`ifdef HUFF_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0] sym_count,
    output logic [CNT_W-1:0] bit_count
`endif
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e     state_q, state_d;
    logic [4:0] shreg_q, shreg_d;
    logic [2:0] cnt_q, cnt_d;
    logic       bit_valid_q, bit_valid_d;
    logic       enc_err_q, enc_err_d;

    logic       hs;
    logic       legal;
    logic [4:0] code_aligned;
    logic [2:0] code_len;
    logic [2:0] code3;
    logic [3:0] code4;
    logic [4:0] code5;

    // Canonical code table; narrow arithmetic wraps harmlessly for illegal symbols.
    always_comb begin
        legal        = (sym_in != 5'd0) && (sym_in <= 5'd18);
        code3        = sym_in[2:0] - 3'd1;
        code4        = sym_in[3:0] + 4'd1;
        code5        = sym_in + 5'd13;
        code_aligned = '0;
        code_len     = '0;
        if (sym_in <= 5'd2) begin
            code_len     = 3'd3;
            code_aligned = {code3, 2'b00};
        end else if (sym_in <= 5'd10) begin
            code_len     = 3'd4;
            code_aligned = {code4, 1'b0};
        end else begin
            code_len     = 3'd5;
            code_aligned = code5;
        end
    end

    // Ready only from registered state; the last-bit cycle allows a gapless reload.
    assign sym_ready = (state_q == StIdle) || ((state_q == StShift) && (cnt_q == 3'd1));
    assign hs        = sym_valid && sym_ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        enc_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    if (legal) begin
                        state_d = StShift;
                        shreg_d = code_aligned;
                        cnt_d   = code_len;
                    end else begin
                        enc_err_d = 1'b1;
                    end
                end
            end
            StShift: begin
                shreg_d = {shreg_q[3:0], 1'b0};
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StIdle;
                    shreg_d = '0;
                    cnt_d   = '0;
                    if (hs) begin
                        if (legal) begin
                            state_d = StShift;
                            shreg_d = code_aligned;
                            cnt_d   = code_len;
                        end else begin
                            enc_err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
        bit_valid_d = (state_d == StShift);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            bit_valid_q <= 1'b0;
            enc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            bit_valid_q <= bit_valid_d;
            enc_err_q   <= enc_err_d;
        end
    end

    // shreg is cleared whenever no code is in flight, so bit_out is 0 when idle.
    assign bit_out   = shreg_q[4];
    assign bit_valid = bit_valid_q;
    assign enc_err   = enc_err_q;

`ifdef HUFF_ENC_STATS_EN
    logic [CNT_W-1:0] sym_count_q, sym_count_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;

    always_comb begin
        sym_count_d = sym_count_q;
        bit_count_d = bit_count_q;
        if (hs && legal && (sym_count_q != {CNT_W{1'b1}})) begin
            sym_count_d = sym_count_q + CNT_W'(1);
        end
        if (bit_valid_q && (bit_count_q != {CNT_W{1'b1}})) begin
            bit_count_d = bit_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sym_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            sym_count_q <= sym_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign sym_count = sym_count_q;
    assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Randomized self-checking bench for huffman_encoder against a queue-based bit-stream model.
// Statistics checks are compiled in when HUFF_ENC_STATS_EN is defined.
module tb_huffman_encoder;

    localparam int unsigned CntW   = 4;
    localparam int          CntMax = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       enc_err;
`ifdef HUFF_ENC_STATS_EN
    logic [CntW-1:0] sym_count;
    logic [CntW-1:0] bit_count;
`endif

    always #5 clk = ~clk;

    huffman_encoder #(.CNT_W(CntW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .enc_err   (enc_err)
`ifdef HUFF_ENC_STATS_EN
        ,
        .sym_count (sym_count),
        .bit_count (bit_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bits still owed on the link, pending error pulse, expected counters.
    bit exp_q[$];
    bit err_exp;
    int sc_exp;
    int bc_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int code_len(input int s);
        if (s <= 2) return 3;
        if (s <= 10) return 4;
        return 5;
    endfunction

    function automatic int code_val(input int s);
        if (s <= 2) return s - 1;
        if (s <= 10) return s + 1;
        return s + 13;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        err_exp = 1'b0;
        sc_exp  = 0;
        bc_exp  = 0;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
    task automatic step(output bit hs_o);
        bit hs;
        bit legal;
        bit was_valid;
        int s;
        int c;
        @(negedge clk);
        check_eq("bit_valid", bit_valid, exp_q.size() > 0);
        check_eq("bit_out", bit_out, (exp_q.size() > 0) ? exp_q[0] : 1'b0);
        check_eq("sym_ready", sym_ready, exp_q.size() <= 1);
        check_eq("enc_err", enc_err, err_exp);
`ifdef HUFF_ENC_STATS_EN
        check_eq("sym_count", sym_count, sc_exp);
        check_eq("bit_count", bit_count, bc_exp);
`endif
        s     = int'(sym_in);
        hs    = sym_valid && (exp_q.size() <= 1);
        legal = (s >= 1) && (s <= 18);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            was_valid = exp_q.size() > 0;
            if (was_valid) void'(exp_q.pop_front());
            err_exp = hs && !legal;
            if (hs && legal) begin
                c = code_val(s);
                for (int i = code_len(s) - 1; i >= 0; i--) exp_q.push_back(c[i]);
                if (sc_exp < CntMax) sc_exp++;
            end
            if (was_valid && bc_exp < CntMax) bc_exp++;
        end
        hs_o = hs && !rst;
        #1;
    endtask

    // Present a symbol with sym_valid held until the model says it was taken.
    task automatic send(input int s);
        bit hs;
        sym_in    = 5'(s);
        sym_valid = 1'b1;
        hs        = 1'b0;
        for (int k = 0; k < 20 && !hs; k++) step(hs);
        check_eq("send_accept", hs, 1'b1);
    endtask

    task automatic idle(input int n);
        bit hs;
        sym_valid = 1'b0;
        for (int k = 0; k < n; k++) step(hs);
    endtask

    initial begin
        bit h;
        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();

        // Single symbol, then back-to-back stream with valid held high.
        send(1);
        idle(5);
        send(2);
        send(10);
        send(18);
        idle(15);

        // Full table sweep.
        for (int s = 1; s <= 18; s++) send(s);
        idle(8);

        // Illegal symbols.
        send(0);
        send(19);
        send(31);
        idle(3);

        // Reset two bits into a length-5 code, then a fresh symbol.
        send(11);
        sym_valid = 1'b0;
        step(h);
        rst = 1'b1;
        step(h);
        rst = 1'b0;
        idle(2);
        send(3);
        idle(6);

`ifdef HUFF_ENC_STATS_EN
        rst = 1'b1;
        step(h);
        rst = 1'b0;
        send(5);
        send(0);
        send(12);
        idle(8);
        check_eq("stats_sym", sym_count, 2);
        check_eq("stats_bit", bit_count, 9);
        for (int k = 0; k < 20; k++) send(1);
        idle(5);
        check_eq("stats_sat", sym_count, CntMax);
`endif

        // Randomized traffic with occasional illegal symbols and resets.
        for (int k = 0; k < 2000; k++) begin
            rst       = ($urandom_range(0, 199) == 0);
            sym_valid = ($urandom_range(0, 9) < 6);
            sym_in    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(1, 18));
            step(h);
        end
        rst = 1'b0;
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
